// File: rtl/q_encode_83_irq_if.sv
`default_nettype none
// ============================================================================
// Module      : q_encode_83_irq_if
// Description : Event-code handshake bundle between the encoder and its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface q_encode_83_irq_if;
    logic [2:0] code_out;
    logic       valid;
    logic       ack;
    logic [7:0] pending_out;
    logic       overflow;

    modport master (
        output code_out,
        output valid,
        output pending_out,
        output overflow,
        input  ack
    );

    modport slave (
        input  code_out,
        input  valid,
        input  pending_out,
        input  overflow,
        output ack
    );
endinterface
`default_nettype wire

// File: rtl/q_encode_83_irq.sv
`default_nettype none
// ============================================================================
// Module      : q_encode_83_irq
// Description : Captures rising edges on eight async request lines and presents
//               the highest-priority pending event as a 3-bit code (valid/ack).
// Revision    : 1.0 - initial release
// ============================================================================
module q_encode_83_irq #(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        req_in,
    q_encode_83_irq_if.master evt
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_s1;
    logic [7:0] r_s2;
    logic [7:0] r_s3;
    logic [7:0] r_pending;
    logic [2:0] r_code;
    logic       r_valid;
    logic       r_overflow;

    logic [7:0] w_edge;
    logic [7:0] w_clr;
    logic [2:0] w_sel;

    assign w_edge = r_s2 & ~r_s3;
    assign w_clr  = (r_valid && evt.ack) ? (8'd1 << r_code) : 8'd0;

    // Scan order makes the last set bit seen the winner.
    always_comb begin
        w_sel = 3'd0;
        if (PRIO_MSB) begin
            for (int i = 0; i < 8; i++) begin
                if (r_pending[i]) w_sel = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (r_pending[i]) w_sel = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1       <= 8'd0;
            r_s2       <= 8'd0;
            r_s3       <= 8'd0;
            r_pending  <= 8'd0;
            r_overflow <= 1'b0;
        end else begin
            r_s1       <= req_in;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            // A new edge on a bit being acknowledged re-pends it.
            r_pending  <= (r_pending & ~w_clr) | w_edge;
            r_overflow <= |(w_edge & r_pending & ~w_clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_code  <= 3'd0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pending != 8'd0) begin
                        r_code  <= w_sel;
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // Code is frozen until acknowledged; no preemption.
                    if (evt.ack) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign evt.code_out    = r_code;
    assign evt.valid       = r_valid;
    assign evt.pending_out = r_pending;
    assign evt.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_q_encode_83_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_q_encode_83_irq
// Description : Self-checking bench for q_encode_83_irq, both priority orders.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_q_encode_83_irq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_in;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q0[$];
    logic [2:0] exp_q1[$];

    q_encode_83_irq_if evt0();
    q_encode_83_irq_if evt1();

    q_encode_83_irq #(.PRIO_MSB(1'b1)) dut_msb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_in (req_in),
        .evt    (evt0)
    );

    q_encode_83_irq #(.PRIO_MSB(1'b0)) dut_lsb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_in (req_in),
        .evt    (evt1)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_in = 8'd0; evt0.ack = 1'b0; evt1.ack = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_in = 8'd0; evt0.ack = 1'b0; evt1.ack = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            step(1);
            checks++;
            if ({evt0.code_out, evt0.valid, evt0.pending_out, evt0.overflow} !== 13'd0) begin
                errors++;
                $display("FAIL reset_state cyc %0d: code=%0d valid=%b pend=%h ovf=%b, want all 0",
                         c, evt0.code_out, evt0.valid, evt0.pending_out, evt0.overflow);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1);
            checks++;
            if ({evt0.valid, evt0.pending_out, evt0.overflow} !== 10'd0) begin
                errors++;
                $display("FAIL idle_after_reset cyc %0d: valid=%b pend=%h ovf=%b, want 0",
                         c, evt0.valid, evt0.pending_out, evt0.overflow);
            end
        end
    endtask

    task automatic test_single();
        logic [2:0] exp;
        do_reset();
        req_in = 8'h20;
        exp_q0.push_back(3'd5);
        step(1); req_in = 8'd0;
        step(2);
        checks++;
        if (evt0.pending_out !== 8'h20 || evt0.valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_e3: pend=%h valid=%b, want pend=20 valid=0",
                     evt0.pending_out, evt0.valid);
        end
        step(1);
        checks++;
        if (evt0.valid !== 1'b1 || evt0.code_out !== 3'd5) begin
            errors++;
            $display("FAIL single_valid_e4: valid=%b code=%0d, want valid=1 code=5",
                     evt0.valid, evt0.code_out);
        end
        for (int c = 0; c < 10; c++) begin
            step(1);
            checks++;
            if (evt0.valid !== 1'b1 || evt0.code_out !== 3'd5 || evt0.pending_out !== 8'h20) begin
                errors++;
                $display("FAIL single_hold cyc %0d: valid=%b code=%0d pend=%h, want 1/5/20",
                         c, evt0.valid, evt0.code_out, evt0.pending_out);
            end
        end
        checks++;
        exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 3'bxxx;
        if (evt0.code_out !== exp) begin
            errors++;
            $display("FAIL single_sb: code=%0d want %0d", evt0.code_out, exp);
        end
        evt0.ack = 1'b1;
        step(1);
        evt0.ack = 1'b0;
        checks++;
        if (evt0.valid !== 1'b0 || evt0.pending_out !== 8'h00) begin
            errors++;
            $display("FAIL single_ack: valid=%b pend=%h, want 0/00", evt0.valid, evt0.pending_out);
        end
    endtask

    task automatic test_priority();
        logic [2:0] exp;
        int last0 = -1;
        int last1 = -1;
        do_reset();
        req_in = 8'b1000_0101;
        exp_q0.push_back(3'd7); exp_q0.push_back(3'd2); exp_q0.push_back(3'd0);
        exp_q1.push_back(3'd0); exp_q1.push_back(3'd2); exp_q1.push_back(3'd7);
        step(1);
        req_in = 8'd0;
        evt0.ack = 1'b1; evt1.ack = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step(1);
            if (evt0.valid === 1'b1) begin
                checks++;
                exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 3'bxxx;
                if (evt0.code_out !== exp) begin
                    errors++;
                    $display("FAIL prio_msb_order: code=%0d want %0d", evt0.code_out, exp);
                end
                if (last0 >= 0) begin
                    checks++;
                    if (c - last0 != 2) begin
                        errors++;
                        $display("FAIL prio_msb_gap: spacing=%0d want 2", c - last0);
                    end
                end
                last0 = c;
            end
            if (evt1.valid === 1'b1) begin
                checks++;
                exp = (exp_q1.size() > 0) ? exp_q1.pop_front() : 3'bxxx;
                if (evt1.code_out !== exp) begin
                    errors++;
                    $display("FAIL prio_lsb_order: code=%0d want %0d", evt1.code_out, exp);
                end
                if (last1 >= 0) begin
                    checks++;
                    if (c - last1 != 2) begin
                        errors++;
                        $display("FAIL prio_lsb_gap: spacing=%0d want 2", c - last1);
                    end
                end
                last1 = c;
            end
        end
        evt0.ack = 1'b0; evt1.ack = 1'b0;
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL prio_count: left msb=%0d lsb=%0d, want 0/0", exp_q0.size(), exp_q1.size());
            exp_q0.delete(); exp_q1.delete();
        end
    endtask

    task automatic test_no_preempt();
        logic [2:0] exp;
        do_reset();
        req_in = 8'h08;
        exp_q0.push_back(3'd3); exp_q0.push_back(3'd6);
        step(1); req_in = 8'd0;
        for (int k = 0; k < 10 && evt0.valid !== 1'b1; k++) step(1);
        checks++;
        if (evt0.valid !== 1'b1 || evt0.code_out !== 3'd3) begin
            errors++;
            $display("FAIL preempt_first: valid=%b code=%0d, want 1/3", evt0.valid, evt0.code_out);
        end
        req_in = 8'h40;
        for (int c = 0; c < 6; c++) begin
            step(1);
            checks++;
            if (evt0.valid !== 1'b1 || evt0.code_out !== 3'd3) begin
                errors++;
                $display("FAIL preempt_hold cyc %0d: valid=%b code=%0d, want 1/3",
                         c, evt0.valid, evt0.code_out);
            end
        end
        checks++;
        exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 3'bxxx;
        if (evt0.code_out !== exp) begin
            errors++;
            $display("FAIL preempt_sb1: code=%0d want %0d", evt0.code_out, exp);
        end
        evt0.ack = 1'b1; step(1); evt0.ack = 1'b0;
        req_in = 8'd0;
        checks++;
        if (evt0.valid !== 1'b0 || evt0.pending_out !== 8'h40) begin
            errors++;
            $display("FAIL preempt_after_ack: valid=%b pend=%h, want 0/40", evt0.valid, evt0.pending_out);
        end
        for (int k = 0; k < 10 && evt0.valid !== 1'b1; k++) step(1);
        checks++;
        exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 3'bxxx;
        if (evt0.valid !== 1'b1 || evt0.code_out !== exp) begin
            errors++;
            $display("FAIL preempt_sb2: valid=%b code=%0d want 1/%0d", evt0.valid, evt0.code_out, exp);
        end
        evt0.ack = 1'b1; step(1); evt0.ack = 1'b0;
        checks++;
        if (evt0.pending_out !== 8'h00) begin
            errors++;
            $display("FAIL preempt_drain: pend=%h want 00", evt0.pending_out);
        end
    endtask

    task automatic test_overflow();
        logic [2:0] exp;
        int ovf_cnt = 0;
        int extra   = 0;
        do_reset();
        req_in = 8'h10;
        exp_q0.push_back(3'd4);
        step(1); req_in = 8'd0;
        for (int k = 0; k < 10 && evt0.valid !== 1'b1; k++) step(1);
        req_in = 8'h10;
        step(1); req_in = 8'd0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (evt0.overflow === 1'b1) ovf_cnt++;
        end
        checks++;
        if (ovf_cnt != 1 || evt0.pending_out !== 8'h10) begin
            errors++;
            $display("FAIL ovf_pulse: pulses=%0d pend=%h, want 1/10", ovf_cnt, evt0.pending_out);
        end
        checks++;
        exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 3'bxxx;
        if (evt0.valid !== 1'b1 || evt0.code_out !== exp) begin
            errors++;
            $display("FAIL ovf_sb: valid=%b code=%0d want 1/%0d", evt0.valid, evt0.code_out, exp);
        end
        evt0.ack = 1'b1; step(1); evt0.ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (evt0.valid === 1'b1 || evt0.pending_out !== 8'h00) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ovf_single_clear: busy cycles=%0d want 0", extra);
        end

        // Set-wins: new edge on bit 4 lands in the ack cycle.
        req_in = 8'h10;
        exp_q0.push_back(3'd4); exp_q0.push_back(3'd4);
        step(1); req_in = 8'd0;
        for (int k = 0; k < 10 && evt0.valid !== 1'b1; k++) step(1);
        req_in = 8'h10;
        step(1); req_in = 8'd0;
        step(1);
        checks++;
        exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 3'bxxx;
        if (evt0.valid !== 1'b1 || evt0.code_out !== exp) begin
            errors++;
            $display("FAIL setwin_sb1: valid=%b code=%0d want 1/%0d", evt0.valid, evt0.code_out, exp);
        end
        evt0.ack = 1'b1; step(1); evt0.ack = 1'b0;
        checks++;
        if (evt0.valid !== 1'b0 || evt0.pending_out !== 8'h10 || evt0.overflow !== 1'b0) begin
            errors++;
            $display("FAIL setwin_repend: valid=%b pend=%h ovf=%b, want 0/10/0",
                     evt0.valid, evt0.pending_out, evt0.overflow);
        end
        step(1);
        checks++;
        exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 3'bxxx;
        if (evt0.valid !== 1'b1 || evt0.code_out !== exp) begin
            errors++;
            $display("FAIL setwin_sb2: valid=%b code=%0d want 1/%0d", evt0.valid, evt0.code_out, exp);
        end
        evt0.ack = 1'b1; step(1); evt0.ack = 1'b0;
        checks++;
        if (evt0.valid !== 1'b0 || evt0.pending_out !== 8'h00) begin
            errors++;
            $display("FAIL setwin_drain: valid=%b pend=%h, want 0/00", evt0.valid, evt0.pending_out);
        end
    endtask

    task automatic test_async_reset();
        int busy = 0;
        do_reset();
        req_in = 8'h2A;
        step(1); req_in = 8'd0;
        for (int k = 0; k < 10 && evt0.valid !== 1'b1; k++) step(1);
        checks++;
        if (evt0.valid !== 1'b1 || evt0.pending_out !== 8'h2A || evt0.code_out !== 3'd5) begin
            errors++;
            $display("FAIL arst_setup: valid=%b pend=%h code=%0d, want 1/2a/5",
                     evt0.valid, evt0.pending_out, evt0.code_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({evt0.code_out, evt0.valid, evt0.pending_out, evt0.overflow} !== 13'd0) begin
            errors++;
            $display("FAIL arst_immediate: code=%0d valid=%b pend=%h ovf=%b, want all 0",
                     evt0.code_out, evt0.valid, evt0.pending_out, evt0.overflow);
        end
        step(1);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step(1);
            if (evt0.valid !== 1'b0 || evt0.pending_out !== 8'h00) busy++;
        end
        checks++;
        if (busy != 0) begin
            errors++;
            $display("FAIL arst_no_events: busy cycles=%0d want 0", busy);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        req_in   = 8'd0;
        evt0.ack = 1'b0;
        evt1.ack = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_overflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
